// File: rtl/id_pipe_stage.sv
// Instruction-decode pipeline stage: register file with optional
// write-back forwarding, load-use hazard detection, and the ID/EX register.
module id_pipe_stage #(
  parameter int XLEN     = 32,
  parameter int NREG     = 64,
  parameter int CTRL_W   = 11,
  parameter int MEMR_BIT = 1,
  parameter int IMM_W    = 16,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 1,
  localparam int RIDX    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [31:0]       instr,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              wb_en,
  input  logic [RIDX-1:0]   wb_idx,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [RIDX-1:0]   out_rd,
  output logic [XLEN-1:0]   out_rs_val,
  output logic [XLEN-1:0]   out_rt_val,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              hazard
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [RIDX-1:0]   rd;
    logic [XLEN-1:0]   rs_val;
    logic [XLEN-1:0]   rt_val;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  idex_t q;

  logic [XLEN-1:0] rf [NREG];

  logic [RIDX-1:0] rd_idx;
  logic [1:0][RIDX-1:0] rp_idx;   // [0]=rs, [1]=rt
  logic [1:0][XLEN-1:0] rp_val;
  logic [XLEN-1:0] imm_sx;
  logic            accept;
  logic            rd_live;
  logic            unused_bits;

  assign rd_idx    = instr[27 -: RIDX];
  assign rp_idx[0] = instr[27-RIDX -: RIDX];
  assign rp_idx[1] = instr[27-2*RIDX -: RIDX];
  assign imm_sx    = {{(XLEN-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
  assign unused_bits = ^instr[31:28];

  // Read ports: hardwired zero, then same-cycle write-back forward, then array.
  for (genvar p = 0; p < 2; p++) begin : g_rport
    assign rp_val[p] = (ZERO_R0 != 0 && rp_idx[p] == '0)               ? '0 :
                       (BYPASS != 0 && wb_en && wb_idx == rp_idx[p])   ? wb_data :
                                                                         rf[rp_idx[p]];
  end

  // A load in ID/EX whose destination feeds this instruction must wait a cycle.
  assign rd_live  = (ZERO_R0 == 0) || (q.rd != '0);
  assign hazard   = in_valid && q.valid && q.ctrl[MEMR_BIT] && rd_live &&
                    (q.rd == rp_idx[0] || q.rd == rp_idx[1]);
  assign in_ready = !hazard && !ex_stall;
  assign accept   = in_valid && in_ready;

  // Register file write; r0 stays zero when hardwired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en && !(ZERO_R0 != 0 && wb_idx == '0)) begin
      rf[wb_idx] <= wb_data;
    end
  end

  // ID/EX register: flush beats stall beats accept; otherwise insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
      q.ctrl  <= '0;
    end else if (ex_stall) begin
      q <= q;
    end else if (accept) begin
      q.valid  <= 1'b1;
      q.pc     <= pc_in;
      q.rd     <= rd_idx;
      q.rs_val <= rp_val[0];
      q.rt_val <= rp_val[1];
      q.imm    <= imm_sx;
      q.ctrl   <= ctrl_in;
    end else begin
      q.valid <= 1'b0;
      q.ctrl  <= '0;
    end
  end

  assign out_valid  = q.valid;
  assign out_pc     = q.pc;
  assign out_rd     = q.rd;
  assign out_rs_val = q.rs_val;
  assign out_rt_val = q.rt_val;
  assign out_imm    = q.imm;
  assign out_ctrl   = q.ctrl;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Bench for id_pipe_stage: directed scenarios plus randomized traffic,
// checked against a behavioural model of the stage. A second instance with
// forwarding disabled shares all inputs to show the non-bypass capture.
module tb_id_pipe_stage;
  localparam int XLEN = 32, NREG = 64, RIDX = 6, CW = 11, VW = 1+XLEN+RIDX+3*XLEN+CW;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 0, wb_en = 0, ex_stall = 0, flush = 0;
  logic [XLEN-1:0] pc_in = '0, wb_data = '0;
  logic [31:0] instr = '0;
  logic [CW-1:0] ctrl_in = '0;
  logic [RIDX-1:0] wb_idx = '0;

  logic in_ready, out_valid, hazard;
  logic [XLEN-1:0] out_pc, out_rs_val, out_rt_val, out_imm;
  logic [RIDX-1:0] out_rd;
  logic [CW-1:0] out_ctrl;

  logic nb_in_ready, nb_out_valid, nb_hazard;
  logic [XLEN-1:0] nb_out_pc, nb_out_rs_val, nb_out_rt_val, nb_out_imm;
  logic [RIDX-1:0] nb_out_rd;
  logic [CW-1:0] nb_out_ctrl;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  id_pipe_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instr(instr), .ctrl_in(ctrl_in), .wb_en(wb_en),
    .wb_idx(wb_idx), .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_rd(out_rd),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .hazard(hazard));

  id_pipe_stage #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nb_in_ready),
    .pc_in(pc_in), .instr(instr), .ctrl_in(ctrl_in), .wb_en(wb_en),
    .wb_idx(wb_idx), .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush),
    .out_valid(nb_out_valid), .out_pc(nb_out_pc), .out_rd(nb_out_rd),
    .out_rs_val(nb_out_rs_val), .out_rt_val(nb_out_rt_val), .out_imm(nb_out_imm),
    .out_ctrl(nb_out_ctrl), .hazard(nb_hazard));

  logic [VW-1:0] dut_vec;
  assign dut_vec = {out_valid, out_pc, out_rd, out_rs_val, out_rt_val, out_imm, out_ctrl};

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] regs [NREG];
  logic            m_valid;
  logic [XLEN-1:0] m_pc, m_rs, m_rt, m_imm, m_rs0, m_rt0;
  int              m_rd;
  logic [CW-1:0]   m_ctrl;

  function automatic int f_rd(input logic [31:0] i); return int'((i >> 22) & 32'h3F); endfunction
  function automatic int f_rs(input logic [31:0] i); return int'((i >> 16) & 32'h3F); endfunction
  function automatic int f_rt(input logic [31:0] i); return int'((i >> 10) & 32'h3F); endfunction

  function automatic logic [XLEN-1:0] f_imm(input logic [31:0] i);
    logic [31:0] lo;
    lo = i & 32'hFFFF;
    return (lo >= 32'h8000) ? (lo | 32'hFFFF_0000) : lo;
  endfunction

  function automatic logic [XLEN-1:0] m_read(input int idx, input bit bypass);
    if (idx == 0) return '0;
    if (bypass && wb_en && int'(wb_idx) == idx) return wb_data;
    return regs[idx];
  endfunction

  function automatic logic m_hazard();
    return in_valid && m_valid && m_ctrl[1] && m_rd != 0 &&
           (m_rd == f_rs(instr) || m_rd == f_rt(instr));
  endfunction

  function automatic logic [VW-1:0] m_vec();
    return {m_valid, m_pc, RIDX'(m_rd), m_rs, m_rt, m_imm, m_ctrl};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) regs[i] = '0;
    m_valid = 0; m_pc = '0; m_rd = 0; m_rs = '0; m_rt = '0; m_imm = '0;
    m_ctrl = '0; m_rs0 = '0; m_rt0 = '0;
  endtask

  // Advance one clock: evaluate the model on the pre-edge inputs, then
  // leave the bench 1 time unit past the edge for checking and driving.
  task automatic cycle();
    logic acc;
    logic [XLEN-1:0] rs1, rt1, rs0, rt0;
    acc = in_valid && !m_hazard() && !ex_stall;
    rs1 = m_read(f_rs(instr), 1); rt1 = m_read(f_rt(instr), 1);
    rs0 = m_read(f_rs(instr), 0); rt0 = m_read(f_rt(instr), 0);
    @(posedge clk);
    if (flush) begin
      m_valid = 0; m_ctrl = '0;
    end else if (ex_stall) begin
      // hold
    end else if (acc) begin
      m_valid = 1; m_pc = pc_in; m_rd = f_rd(instr); m_rs = rs1; m_rt = rt1;
      m_rs0 = rs0; m_rt0 = rt0; m_imm = f_imm(instr); m_ctrl = ctrl_in;
    end else begin
      m_valid = 0; m_ctrl = '0;
    end
    if (wb_en && wb_idx != '0) regs[wb_idx] = wb_data;
    #1;
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs, input int rt, input logic [15:0] imm);
    logic [31:0] v;
    v = ($urandom() & 32'hF000_0000) | (32'(rd) << 22) | (32'(rs) << 16) |
        (32'(rt) << 10) | (32'(imm) & 32'h03FF);
    return v;
  endfunction

  task automatic idle();
    in_valid = 0; wb_en = 0; ex_stall = 0; flush = 0; ctrl_in = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    in_valid = 1; instr = mk(1, 2, 3, 16'h0);
    #2;
    checks++; if (dut_vec !== '0) begin failures++;
      $display("FAIL reset_outputs got=%h exp=0", dut_vec); end
    checks++; if (hazard !== 1'b0) begin failures++;
      $display("FAIL reset_hazard got=%b exp=0", hazard); end
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1; idle();
    cycle();
  endtask

  task automatic test_basic();
    wb_en = 1; wb_idx = 5; wb_data = 32'h1234;
    cycle();
    idle(); in_valid = 1; pc_in = 32'h100; instr = mk(9, 5, 0, 16'h7);
    ctrl_in = 11'h004;
    cycle();
    checks++; if (out_valid !== 1'b1 || out_rs_val !== 32'h1234) begin failures++;
      $display("FAIL basic_rs got v=%b rs=%h exp v=1 rs=1234", out_valid, out_rs_val); end
    checks++; if (dut_vec !== m_vec()) begin failures++;
      $display("FAIL basic_vec got=%h exp=%h", dut_vec, m_vec()); end
    idle(); cycle();
  endtask

  task automatic test_bypass();
    wb_en = 1; wb_idx = 7; wb_data = 32'h1111;
    cycle();
    wb_data = 32'hCAFE; in_valid = 1; pc_in = 32'h200; instr = mk(2, 7, 0, 16'h0);
    cycle();
    checks++; if (out_rs_val !== 32'hCAFE) begin failures++;
      $display("FAIL bypass_new got=%h exp=cafe", out_rs_val); end
    checks++; if (nb_out_rs_val !== 32'h1111 || nb_out_rs_val !== m_rs0) begin failures++;
      $display("FAIL nobypass_old got=%h exp=1111", nb_out_rs_val); end
    idle(); cycle();
  endtask

  task automatic test_hazard();
    in_valid = 1; pc_in = 32'h300; instr = mk(3, 1, 2, 16'h0); ctrl_in = 11'h002;
    cycle();
    pc_in = 32'h304; instr = mk(4, 3, 0, 16'h0); ctrl_in = 11'h000;
    #1;
    checks++; if (hazard !== 1'b1 || in_ready !== 1'b0) begin failures++;
      $display("FAIL hazard_detect got hz=%b rdy=%b exp hz=1 rdy=0", hazard, in_ready); end
    cycle();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin failures++;
      $display("FAIL hazard_bubble got v=%b ctrl=%h exp v=0 ctrl=0", out_valid, out_ctrl); end
    checks++; if (hazard !== 1'b0 || in_ready !== 1'b1) begin failures++;
      $display("FAIL hazard_clear got hz=%b rdy=%b exp hz=0 rdy=1", hazard, in_ready); end
    cycle();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h304 || dut_vec !== m_vec()) begin failures++;
      $display("FAIL hazard_accept got=%h exp=%h", dut_vec, m_vec()); end
    idle(); cycle();
  endtask

  task automatic test_stall();
    in_valid = 1; pc_in = 32'h400; instr = mk(6, 5, 7, 16'h1234); ctrl_in = 11'h010;
    cycle();
    pc_in = 32'h404; instr = mk(8, 7, 5, 16'h0); ctrl_in = 11'h020; ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (dut_vec !== m_vec() || out_pc !== 32'h400 || in_ready !== 1'b0) begin failures++;
        $display("FAIL stall_hold[%0d] got=%h rdy=%b exp=%h rdy=0", i, dut_vec, in_ready, m_vec()); end
    end
    ex_stall = 0;
    cycle();
    checks++; if (out_pc !== 32'h404 || out_valid !== 1'b1 || dut_vec !== m_vec()) begin failures++;
      $display("FAIL stall_release got=%h exp=%h", dut_vec, m_vec()); end
    idle(); cycle();
  endtask

  task automatic test_flush_imm();
    in_valid = 1; pc_in = 32'h500; instr = mk(10, 0, 32, 16'h8000); ctrl_in = 11'h7FF;
    cycle();
    checks++; if (out_imm !== 32'hFFFF_8000) begin failures++;
      $display("FAIL imm_sext got=%h exp=ffff8000", out_imm); end
    pc_in = 32'h504; instr = mk(11, 0, 0, 16'h1); flush = 1;
    cycle();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_pc !== 32'h500) begin failures++;
      $display("FAIL flush got v=%b ctrl=%h pc=%h exp v=0 ctrl=0 pc=500", out_valid, out_ctrl, out_pc); end
    idle(); cycle();
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL flush_discard got v=%b exp 0", out_valid); end
  endtask

  task automatic test_zero_r0();
    wb_en = 1; wb_idx = 0; wb_data = 32'h55;
    cycle();
    in_valid = 1; pc_in = 32'h600; instr = mk(1, 0, 0, 16'h0);
    cycle();
    checks++; if (out_rs_val !== '0 || out_rt_val !== '0) begin failures++;
      $display("FAIL zero_r0 got rs=%h rt=%h exp 0", out_rs_val, out_rt_val); end
    idle(); cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      pc_in    = $urandom();
      instr    = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    16'($urandom()));
      ctrl_in  = CW'($urandom());
      wb_en    = $urandom_range(0, 1);
      wb_idx   = RIDX'($urandom_range(0, 7));
      wb_data  = $urandom();
      ex_stall = ($urandom_range(0, 99) < 15);
      flush    = ($urandom_range(0, 99) < 8);
      #1;
      checks++; if (hazard !== m_hazard() || in_ready !== (!m_hazard() && !ex_stall)) begin failures++;
        $display("FAIL rand_comb[%0d] got hz=%b rdy=%b exp hz=%b", n, hazard, in_ready, m_hazard()); end
      cycle();
      checks++; if (dut_vec !== m_vec() || nb_out_rs_val !== m_rs0 || nb_out_rt_val !== m_rt0) begin failures++;
        $display("FAIL rand_out[%0d] got=%h exp=%h", n, dut_vec, m_vec()); end
    end
    idle(); cycle();
  endtask

  task automatic test_reset_mid();
    wb_en = 1; wb_idx = 5; wb_data = 32'hBEEF;
    cycle();
    wb_en = 0; in_valid = 1; pc_in = 32'h700; instr = mk(5, 1, 1, 16'h0); ctrl_in = 11'h002;
    cycle();
    instr = mk(2, 5, 5, 16'h0);
    rst_n = 0;
    #1;
    checks++; if (dut_vec !== '0 || hazard !== 1'b0) begin failures++;
      $display("FAIL reset_mid got=%h hz=%b exp 0", dut_vec, hazard); end
    m_reset();
    #3 rst_n = 1;
    pc_in = 32'h708; ctrl_in = '0;
    cycle();
    checks++; if (out_rs_val !== '0 || dut_vec !== m_vec()) begin failures++;
      $display("FAIL reset_rf got rs=%h exp 0", out_rs_val); end
    idle(); cycle();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_bypass();
    test_hazard();
    test_stall();
    test_flush_imm();
    test_zero_r0();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_pipe_stage.md
ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, meaning datapath, register and PC width.
REQ-002 The block SHALL take parameter NREG, default 64, meaning register-file entries; RIDX = clog2(NREG), and 3*RIDX <= 28.
REQ-003 The block SHALL take parameter CTRL_W, default 11, meaning control-bundle width.
REQ-004 The block SHALL take parameter MEMR_BIT, default 1, meaning index of the memory-read flag within ctrl_in.
REQ-005 The block SHALL take parameter IMM_W, default 16, meaning immediate field width at instr[IMM_W-1:0].
REQ-006 The block SHALL take parameter BYPASS, default 1, meaning 1 enables same-cycle write-back-to-read forwarding.
REQ-007 The block SHALL take parameter ZERO_R0, default 1, meaning 1 makes register 0 read as 0 and ignore writes.
REQ-008 The ports SHALL be:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
pc_in  in  XLEN  PC of incoming instruction
instr  in  32  incoming instruction
ctrl_in  in  CTRL_W  decoded control bundle for instr
wb_en  in  1  register write enable
wb_idx  in  RIDX  write register index
wb_data  in  XLEN  write data
ex_stall  in  1  downstream cannot accept; hold outputs
flush  in  1  kill the instruction being registered
out_valid  out  1  ID/EX register holds a live instruction
out_pc  out  XLEN  registered PC
out_rd  out  RIDX  registered destination index
out_rs_val  out  XLEN  registered rs operand
out_rt_val  out  XLEN  registered rt operand
out_imm  out  XLEN  registered sign-extended immediate
out_ctrl  out  CTRL_W  registered control bundle
hazard  out  1  load-use hazard detected (combinational)

Function
REQ-009 Fields SHALL be rd = instr[27 -: RIDX], rs = instr[27-RIDX -: RIDX], rt = instr[27-2*RIDX -: RIDX]; with defaults rd=[27:22], rs=[21:16], rt=[15:10].
REQ-010 The register file SHALL hold NREG x XLEN entries written at posedge clk when wb_en=1, except index 0 when ZERO_R0=1.
REQ-011 Reads SHALL be combinational: index 0 gives 0 when ZERO_R0=1; else wb_data when BYPASS=1, wb_en=1 and wb_idx equals the read index; else the stored entry.
REQ-012 hazard SHALL be 1 iff in_valid=1, out_valid=1, out_ctrl[MEMR_BIT]=1, out_rd is nonzero (or ZERO_R0=0), and out_rd equals rs or rt.
REQ-013 in_ready SHALL equal !hazard && !ex_stall.
REQ-014 An instruction SHALL be accepted when in_valid && in_ready.
REQ-015 The ID/EX register SHALL update at each posedge clk by this priority:
- flush=1: out_valid and out_ctrl cleared; other outputs unchanged.
- else ex_stall=1: all outputs hold.
- else accept: load pc_in, rd, operands, sign-extended immediate and ctrl_in; out_valid=1.
- else: bubble, with out_valid and out_ctrl cleared.
REQ-016 When flush=1 and accept=1 in the same cycle, the accepted instruction SHALL be consumed and discarded.
REQ-017 Latency SHALL be one cycle from accept to out_valid=1.
REQ-018 A load-use hazard SHALL insert exactly one bubble, after which hazard falls and the held instruction is accepted.
REQ-019 Write-back and accept in the same cycle SHALL capture the new value when BYPASS=1, and the old value when BYPASS=0.

Reset
REQ-020 While rst_n=0, all ID/EX outputs SHALL be 0 asynchronously, including out_valid=0 and out_ctrl=0.
REQ-021 While rst_n=0, all register-file entries SHALL be 0.
REQ-022 Reset asserted mid-operation SHALL discard the registered instruction with no partial state retained.
REQ-023 hazard SHALL be 0 while in reset, since out_valid=0.

Verification
REQ-024 The bench SHALL cover: write r5=0x1234, then accept rs=5 -> next cycle out_rs_val=0x1234, out_valid=1.
REQ-025 The bench SHALL cover: BYPASS=1, wb r7=0xCAFE in the same cycle as accept rs=7 -> out_rs_val=0xCAFE; with BYPASS=0 -> old value.
REQ-026 The bench SHALL cover: a load with rd=3 registered, next instr rs=3 -> hazard=1, in_ready=0, one bubble with out_valid=0, then instr accepted.
REQ-027 The bench SHALL cover: ex_stall held 3 cycles -> outputs constant, in_ready=0; release -> pending instruction accepted.
REQ-028 The bench SHALL cover: flush with accept -> out_valid=0, out_ctrl=0; instr=0xFFFF8000-style imm 0x8000 -> out_imm=0xFFFF8000.
REQ-029 The bench SHALL cover: write r0=0x55 with ZERO_R0=1 -> read r0 gives 0; rst_n low mid-stream -> all outputs 0 immediately.
